// File: rtl/seq_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : seq_priority_encoder
// Brief    : Sequential N:log2(N) priority encoder. It takes a multi-hot vector
//            and emits the index of each set bit, lowest first. Optional
//            ENC_BEAT_SEQ_EN adds the out_seq beat counter port.
// Revision : 1.0 - initial release
// ============================================================================
module seq_priority_encoder #(
   parameter  int N = 8,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         out_none
`ifdef ENC_BEAT_SEQ_EN
   ,
   output logic [W:0]   out_seq
`endif
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_t;

   localparam logic [N-1:0] c_one     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [W:0]   c_seq_one = {{W{1'b0}}, 1'b1};

   state_t         r_state;
   logic [N-1:0]   r_rem;
   logic [W:0]     r_seq;

   logic           w_in_hs;
   logic           w_out_hs;
   logic [N-1:0]   w_src;
   logic [W-1:0]   w_src_idx;
   logic           w_src_single;

   function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
      lowest_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = W'(i);
      end
   endfunction

   assign w_in_hs  = in_valid & in_ready;
   assign w_out_hs = out_valid & out_ready;

   // One encoder serves both the freshly accepted vector and the remainder
   // after the current lowest bit is cleared (v & (v-1)).
   assign w_src        = (r_state == S_IDLE) ? in_vec : (r_rem & (r_rem - c_one));
   assign w_src_idx    = lowest_idx(w_src);
   assign w_src_single = ((w_src & (w_src - c_one)) == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rem     <= '0;
         r_seq     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         out_none  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_in_hs) begin
                  r_rem     <= in_vec;
                  r_seq     <= '0;
                  out_idx   <= w_src_idx;
                  out_last  <= w_src_single;
                  out_none  <= ~|in_vec;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b0;
                  r_state   <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (w_out_hs) begin
                  if (out_last) begin
                     r_rem     <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_none  <= 1'b0;
                     in_ready  <= 1'b1;
                     r_state   <= S_IDLE;
                  end else begin
                     r_rem    <= w_src;
                     r_seq    <= r_seq + c_seq_one;
                     out_idx  <= w_src_idx;
                     out_last <= w_src_single;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ENC_BEAT_SEQ_EN
   assign out_seq = r_seq;
`else
   logic w_seq_unused;
   assign w_seq_unused = ^r_seq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_priority_encoder
// Brief    : Directed table-driven bench for seq_priority_encoder (N=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_priority_encoder;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_vec;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic         out_last;
   logic         out_none;
`ifdef ENC_BEAT_SEQ_EN
   logic [W:0]   out_seq;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   seq_priority_encoder #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_none  (out_none)
`ifdef ENC_BEAT_SEQ_EN
      ,
      .out_seq   (out_seq)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]      vec;
      int              cnt;
      logic [7:0][2:0] idx;
      logic            none;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_seq(input string name, input int exp);
`ifdef ENC_BEAT_SEQ_EN
      chk(name, 32'(out_seq), exp);
`endif
   endtask

   task automatic run_vec(input string tag, input logic [7:0] v, input int cnt,
                          input logic [7:0][2:0] idx, input logic none);
      in_valid  = 1'b1;
      in_vec    = v;
      out_ready = 1'b1;
      chk({tag, " in_ready_idle"}, 32'(in_ready), 1);
      chk({tag, " valid_idle"}, 32'(out_valid), 0);
      tick();
      in_valid = 1'b0;
      in_vec   = 8'h00;
      for (int k = 0; k < cnt; k++) begin
         chk($sformatf("%s beat%0d valid", tag, k), 32'(out_valid), 1);
         chk($sformatf("%s beat%0d in_ready", tag, k), 32'(in_ready), 0);
         chk($sformatf("%s beat%0d idx", tag, k), 32'(out_idx), 32'(idx[k]));
         chk($sformatf("%s beat%0d last", tag, k), 32'(out_last), (k == cnt - 1) ? 1 : 0);
         chk($sformatf("%s beat%0d none", tag, k), 32'(out_none), 32'(none));
         chk_seq($sformatf("%s beat%0d seq", tag, k), none ? 0 : k);
         tick();
      end
      chk({tag, " valid_after"}, 32'(out_valid), 0);
      chk({tag, " in_ready_after"}, 32'(in_ready), 1);
   endtask

   initial begin
      in_valid  = 1'b0;
      in_vec    = 8'h00;
      out_ready = 1'b0;

      tbl[0] = '{8'b1010_0100, 3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2}, 1'b0};
      tbl[1] = '{8'h00,        1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 1'b1};
      tbl[2] = '{8'hFF,        8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 1'b0};
      tbl[3] = '{8'h80,        1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}, 1'b0};
      tbl[4] = '{8'h81,        2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0}, 1'b0};
      tbl[5] = '{8'h01,        1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 1'b0};

      #1 rst_n = 1'b0;
      #2;
      chk("rst in_ready", 32'(in_ready), 1);
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst out_idx", 32'(out_idx), 0);
      chk("rst out_last", 32'(out_last), 0);
      chk("rst out_none", 32'(out_none), 0);
      chk_seq("rst out_seq", 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      for (int t = 0; t < 6; t++) begin
         run_vec($sformatf("vec%0d", t), tbl[t].vec, tbl[t].cnt, tbl[t].idx, tbl[t].none);
         tick();
      end

      // Backpressure on the middle beat, then a vector offered during the last beat.
      in_valid  = 1'b1;
      in_vec    = 8'b1010_0100;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("bp idx2", 32'(out_idx), 2);
      tick();
      out_ready = 1'b0;
      chk("bp idx5", 32'(out_idx), 5);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("bp hold%0d valid", c), 32'(out_valid), 1);
         chk($sformatf("bp hold%0d idx", c), 32'(out_idx), 5);
         chk($sformatf("bp hold%0d last", c), 32'(out_last), 0);
         chk($sformatf("bp hold%0d none", c), 32'(out_none), 0);
         chk_seq($sformatf("bp hold%0d seq", c), 1);
      end
      out_ready = 1'b1;
      tick();
      chk("bp idx7", 32'(out_idx), 7);
      chk("bp last7", 32'(out_last), 1);
      chk_seq("bp seq7", 2);
      in_valid = 1'b1;
      in_vec   = 8'h08;
      tick();
      chk("bp no_accept valid", 32'(out_valid), 0);
      chk("bp no_accept in_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      in_vec   = 8'h00;
      chk("bp next valid", 32'(out_valid), 1);
      chk("bp next idx", 32'(out_idx), 3);
      chk("bp next last", 32'(out_last), 1);
      tick();
      chk("bp next done", 32'(out_valid), 0);
      tick();

      // Asynchronous reset while emitting.
      in_valid = 1'b1;
      in_vec   = 8'b1010_0100;
      tick();
      in_valid = 1'b0;
      in_vec   = 8'h00;
      chk("ar idx2", 32'(out_idx), 2);
      tick();
      chk("ar idx5", 32'(out_idx), 5);
      rst_n = 1'b0;
      #1;
      chk("ar out_valid", 32'(out_valid), 0);
      chk("ar in_ready", 32'(in_ready), 1);
      chk("ar out_last", 32'(out_last), 0);
      tick();
      rst_n = 1'b1;
      tick();
      run_vec("post_rst", 8'h01, 1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
